// File: rtl/cell_grid_mem.sv
// Life cell grid row memory: one bit per cell, one word per row, with a VGA read port,
// a selector read port plus masked RMW write port, and a built-in full-grid clear sweep.
// Latency: reads are 1 cycle (registered address, combinational array read).
// Backpressure: none. Writes during a sweep are dropped; callers must watch busy.
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   vga_addr / vga_row     VGA row address and read data
//   sel_addr / sel_row     selector row address and read data
//   sel_we/sel_mode/sel_data  write enable, mode (WRITE/SET/CLEAR/TOGGLE), data or mask
//   clear_req              start a full-grid clear
//   busy / clear_done      sweep in progress / one-cycle completion pulse
module cell_grid_mem #(
    parameter int ROW_WIDTH = 16,
    parameter int ROWS      = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    vga_addr,
    output logic [ROW_WIDTH-1:0] vga_row,
    input  logic [ADDR_W-1:0]    sel_addr,
    input  logic                 sel_we,
    input  logic [1:0]           sel_mode,
    input  logic [ROW_WIDTH-1:0] sel_data,
    output logic [ROW_WIDTH-1:0] sel_row,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 clear_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_WRITE  = 2'b00;
    localparam logic [1:0] MODE_SET    = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    // Range checks use one extra bit so ROWS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   ROWS_L   = (ADDR_W+1)'(ROWS);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(ROWS - 1);

    logic [ROW_WIDTH-1:0] mem [ROWS];

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   vga_addr_q;
    logic [ADDR_W-1:0]   sel_addr_q;
    logic                vga_in_range;
    logic                sel_q_in_range;
    logic                sel_in_range;
    logic                sel_wr_en;
    logic                clr_wr_en;
    logic [ROW_WIDTH-1:0] old_row;
    logic [ROW_WIDTH-1:0] new_row;

    assign vga_in_range   = {1'b0, vga_addr_q} < ROWS_L;
    assign sel_q_in_range = {1'b0, sel_addr_q} < ROWS_L;
    assign sel_in_range   = {1'b0, sel_addr}   < ROWS_L;

    // Reads are blanked during the sweep so half-cleared frames never reach the display.
    assign vga_row = (busy || !vga_in_range)   ? '0 : mem[vga_addr_q];
    assign sel_row = (busy || !sel_q_in_range) ? '0 : mem[sel_addr_q];

    // A clear request wins over a same-cycle write in IDLE; DONE accepts writes as normal.
    assign sel_wr_en = rst_n && sel_we && sel_in_range &&
                       ((state == ST_IDLE && !clear_req) || state == ST_DONE);
    assign clr_wr_en = rst_n && (state == ST_CLEAR);

    always_comb begin
        old_row = sel_in_range ? mem[sel_addr] : '0;
        new_row = old_row;
        case (sel_mode)
            MODE_WRITE:  new_row = sel_data;
            MODE_SET:    new_row = old_row | sel_data;
            MODE_CLEAR:  new_row = old_row & ~sel_data;
            MODE_TOGGLE: new_row = old_row ^ sel_data;
            default:     new_row = old_row;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            busy       <= 1'b1;
            clear_done <= 1'b0;
            vga_addr_q <= '0;
            sel_addr_q <= '0;
        end else begin
            vga_addr_q <= vga_addr;
            sel_addr_q <= sel_addr;
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (ptr == LAST_PTR) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array is not reset; the sweep zeroes it row by row.
    always_ff @(posedge clk) begin
        if (clr_wr_en) begin
            mem[ptr] <= '0;
        end else if (sel_wr_en) begin
            mem[sel_addr] <= new_row;
        end
    end

endmodule

// File: tb/tb_cell_grid_mem.sv
module tb_cell_grid_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  vga_addr, sel_addr;
    logic [15:0] vga_row, sel_row, sel_data;
    logic        sel_we, clear_req, busy, clear_done;
    logic [1:0]  sel_mode;

    logic [3:0]  b_vga_addr, b_sel_addr;
    logic [15:0] b_vga_row, b_sel_row, b_sel_data;
    logic        b_sel_we, b_clear_req, b_busy, b_clear_done;
    logic [1:0]  b_sel_mode;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cell_grid_mem #(.ROW_WIDTH(16), .ROWS(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_addr(vga_addr), .vga_row(vga_row),
        .sel_addr(sel_addr), .sel_we(sel_we), .sel_mode(sel_mode),
        .sel_data(sel_data), .sel_row(sel_row),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done)
    );

    cell_grid_mem #(.ROW_WIDTH(16), .ROWS(12), .ADDR_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .vga_addr(b_vga_addr), .vga_row(b_vga_row),
        .sel_addr(b_sel_addr), .sel_we(b_sel_we), .sel_mode(b_sel_mode),
        .sel_data(b_sel_data), .sel_row(b_sel_row),
        .clear_req(b_clear_req), .busy(b_busy), .clear_done(b_clear_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] m, input logic [15:0] d);
        sel_addr = a; sel_mode = m; sel_data = d; sel_we = 1'b1;
        tick();
        sel_we = 1'b0;
    endtask

    // Checks 16 busy windows, then the done pulse, then its deassertion.
    task automatic sweep16(input string tag);
        int dn;
        dn = 0;
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, "_vga0"}, {16'b0, vga_row}, 32'h0);
            chk({tag, "_sel0"}, {16'b0, sel_row}, 32'h0);
            if (clear_done) dn++;
            tick();
        end
        chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        if (clear_done) dn++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (clear_done) dn++;
        end
        chk({tag, "_done_pulses"}, dn, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        vga_addr = '0; sel_addr = '0; sel_we = 1'b0; sel_mode = 2'b00;
        sel_data = '0; clear_req = 1'b0;
        b_vga_addr = '0; b_sel_addr = '0; b_sel_we = 1'b0; b_sel_mode = 2'b00;
        b_sel_data = '0; b_clear_req = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_done", {31'b0, clear_done}, 32'd0);
        chk("rst_vga", {16'b0, vga_row}, 32'h0);

        // Reset release: both instances sweep together.
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("init_busy", {31'b0, busy}, 32'd1);
            chk("init_done_low", {31'b0, clear_done}, 32'd0);
            chk("init12_busy", {31'b0, b_busy}, {31'b0, (i < 12)});
            chk("init12_done", {31'b0, b_clear_done}, {31'b0, (i == 12)});
            tick();
        end
        chk("init_busy_end", {31'b0, busy}, 32'd0);
        chk("init_done_pulse", {31'b0, clear_done}, 32'd1);
        tick();
        chk("init_done_clr", {31'b0, clear_done}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            vga_addr = 4'(i);
            tick();
            chk("init_row_zero", {16'b0, vga_row}, 32'h0);
        end

        // Write modes on row 3, both read ports watching it.
        vga_addr = 4'd3;
        wr(4'd3, 2'b00, 16'hA5A5);
        chk("wr_sel", {16'b0, sel_row}, 32'hA5A5);
        chk("wr_vga", {16'b0, vga_row}, 32'hA5A5);
        wr(4'd3, 2'b01, 16'h000F);
        chk("set_sel", {16'b0, sel_row}, 32'hA5AF);
        chk("set_vga", {16'b0, vga_row}, 32'hA5AF);
        wr(4'd3, 2'b10, 16'hA000);
        chk("clr_sel", {16'b0, sel_row}, 32'h05AF);
        chk("clr_vga", {16'b0, vga_row}, 32'h05AF);
        wr(4'd3, 2'b11, 16'hFFFF);
        chk("tog_sel", {16'b0, sel_row}, 32'hFA50);
        chk("tog_vga", {16'b0, vga_row}, 32'hFA50);

        // Independent ports.
        wr(4'd2, 2'b00, 16'h1234);
        wr(4'd9, 2'b00, 16'h8001);
        vga_addr = 4'd2; sel_addr = 4'd9;
        tick();
        chk("indep_vga", {16'b0, vga_row}, 32'h1234);
        chk("indep_sel", {16'b0, sel_row}, 32'h8001);

        // Fill, then clear request colliding with a write to row 0.
        for (int i = 0; i < 16; i++) wr(4'(i), 2'b00, 16'hFFFF);
        sel_addr = 4'd0; vga_addr = 4'd0;
        tick();
        chk("fill_row0", {16'b0, sel_row}, 32'hFFFF);
        clear_req = 1'b1; sel_we = 1'b1; sel_mode = 2'b00; sel_data = 16'h5555; sel_addr = 4'd0;
        tick();
        clear_req = 1'b0;
        sel_addr = 4'd5; sel_data = 16'hAAAA;   // writes during busy must be dropped
        vga_addr = 4'd5;
        for (int i = 0; i < 16; i++) begin
            chk("cq_busy", {31'b0, busy}, 32'd1);
            chk("cq_vga0", {16'b0, vga_row}, 32'h0);
            chk("cq_sel0", {16'b0, sel_row}, 32'h0);
            if (i == 15) sel_we = 1'b0;
            tick();
        end
        chk("cq_busy_end", {31'b0, busy}, 32'd0);
        chk("cq_done", {31'b0, clear_done}, 32'd1);
        tick();
        chk("cq_done_clr", {31'b0, clear_done}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            vga_addr = 4'(i); sel_addr = 4'(15 - i);
            tick();
            chk("cq_vga_zero", {16'b0, vga_row}, 32'h0);
            chk("cq_sel_zero", {16'b0, sel_row}, 32'h0);
        end

        // Reset mid-sweep at pointer 7.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (7) tick();
        chk("mid_busy_pre", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sweep16("midrst");

        // Non-power-of-two depth instance.
        b_sel_addr = 4'd13; b_sel_mode = 2'b00; b_sel_data = 16'hFFFF; b_sel_we = 1'b1;
        tick();
        b_sel_addr = 4'd11; b_sel_data = 16'hABCD;
        tick();
        b_sel_we = 1'b0;
        b_sel_addr = 4'd13; b_vga_addr = 4'd11;
        tick();
        chk("r12_oob_sel", {16'b0, b_sel_row}, 32'h0);
        chk("r12_row11", {16'b0, b_vga_row}, 32'hABCD);
        b_vga_addr = 4'd13;
        tick();
        chk("r12_oob_vga", {16'b0, b_vga_row}, 32'h0);
        b_clear_req = 1'b1;
        tick();
        b_clear_req = 1'b0;
        b_vga_addr = 4'd11;
        for (int i = 0; i < 12; i++) begin
            chk("r12_busy", {31'b0, b_busy}, 32'd1);
            tick();
        end
        chk("r12_busy_end", {31'b0, b_busy}, 32'd0);
        chk("r12_done", {31'b0, b_clear_done}, 32'd1);
        chk("r12_row11_clr", {16'b0, b_vga_row}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
